// File: rtl/pong_ball_painter.sv
`default_nettype none
// ============================================================================
// Module      : pong_ball_painter
// Description : Once per accepted frame tick, erases the pong ball sprite,
//               moves it one step with wall bounces, and redraws it through
//               the VGA adapter pixel-write port. Owns the ball position and
//               direction state.
//               Optional feature macro: PONG_BALL_SPEED_EN adds a 2-bit speed
//               input; the ball then advances speed+1 pixels per tick.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_ball_painter #(
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter int         BALL_SIZE   = 4,
  parameter int         X_INIT      = 78,
  parameter int         Y_INIT      = 58,
  parameter logic [2:0] BG_COLOUR   = 3'b000,
  parameter logic [2:0] BALL_COLOUR = 3'b111
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       do_erase,
`ifdef PONG_BALL_SPEED_EN
  input  logic [1:0] speed,
`endif
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic [7:0] ball_x,
  output logic [6:0] ball_y
);

  // Pixel counter: low half walks the sprite column, high half the row
  localparam int                    c_HALF_BITS = $clog2(BALL_SIZE);
  localparam int                    c_PIX_BITS  = 2 * c_HALF_BITS;
  localparam logic [c_PIX_BITS-1:0] c_PIX_LAST  = '1;
  localparam logic [c_PIX_BITS-1:0] c_PIX_ONE   = c_PIX_BITS'(1);

  // Largest legal top-left coordinate on each axis
  localparam logic [8:0] c_XMAX = 9'(SCREEN_W - BALL_SIZE);
  localparam logic [8:0] c_YMAX = 9'(SCREEN_H - BALL_SIZE);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ERASE = 3'd2,
    S_MOVE  = 3'd3,
    S_DRAW  = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_PIX_BITS-1:0] r_p;
  logic                  r_pending;
  logic                  r_dir_x;      // 1 = moving towards larger x
  logic                  r_dir_y;      // 1 = moving towards larger y
  logic [7:0]            r_ball_x;
  logic [6:0]            r_ball_y;
  logic [7:0]            r_x;
  logic [6:0]            r_y;
  logic [2:0]            r_colour;
  logic                  r_plot;
  logic                  r_busy;

  logic       w_tick;
  logic [8:0] w_step;
  logic [8:0] w_x9;
  logic [8:0] w_y9;
  logic [7:0] w_next_x;
  logic [6:0] w_next_y;
  logic       w_next_dir_x;
  logic       w_next_dir_y;
  logic [7:0] w_pix_x;
  logic [6:0] w_pix_y;

  assign w_tick = enable & do_erase;

`ifdef PONG_BALL_SPEED_EN
  assign w_step = 9'(speed) + 9'd1;
`else
  assign w_step = 9'd1;
`endif

  // 9-bit views of the position so step arithmetic cannot wrap
  assign w_x9 = {1'b0, r_ball_x};
  assign w_y9 = {2'b00, r_ball_y};

  // Current sprite pixel in raster order (column fastest)
  assign w_pix_x = r_ball_x + 8'(r_p[c_HALF_BITS-1:0]);
  assign w_pix_y = r_ball_y + 7'(r_p[c_PIX_BITS-1:c_HALF_BITS]);

  // Next x position: step in the current direction, reflecting off the walls
  always_comb begin
    w_next_x     = r_ball_x;
    w_next_dir_x = r_dir_x;
    if (r_dir_x) begin
      if (w_x9 + w_step > c_XMAX) begin
        w_next_x     = 8'(c_XMAX - w_step);
        w_next_dir_x = 1'b0;
      end else begin
        w_next_x = 8'(w_x9 + w_step);
      end
    end else begin
      if (w_x9 < w_step) begin
        w_next_x     = 8'(w_step);
        w_next_dir_x = 1'b1;
      end else begin
        w_next_x = 8'(w_x9 - w_step);
      end
    end
  end

  // Next y position: same reflection rule, independent of the x axis
  always_comb begin
    w_next_y     = r_ball_y;
    w_next_dir_y = r_dir_y;
    if (r_dir_y) begin
      if (w_y9 + w_step > c_YMAX) begin
        w_next_y     = 7'(c_YMAX - w_step);
        w_next_dir_y = 1'b0;
      end else begin
        w_next_y = 7'(w_y9 + w_step);
      end
    end else begin
      if (w_y9 < w_step) begin
        w_next_y     = 7'(w_step);
        w_next_dir_y = 1'b1;
      end else begin
        w_next_y = 7'(w_y9 - w_step);
      end
    end
  end

  // Sequencer: tick capture, sprite pixel walk, ball motion and pixel port
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state   <= S_INIT;
      r_p       <= '0;
      r_pending <= 1'b0;
      r_dir_x   <= 1'b1;
      r_dir_y   <= 1'b1;
      r_ball_x  <= 8'(X_INIT);
      r_ball_y  <= 7'(Y_INIT);
      r_x       <= '0;
      r_y       <= '0;
      r_colour  <= BG_COLOUR;
      r_plot    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      // A tick during a running sequence is remembered once; extras are lost
      if ((r_state != S_IDLE) && w_tick) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        S_INIT: begin
          r_plot  <= 1'b0;
          r_busy  <= 1'b1;
          r_p     <= '0;
          r_state <= S_DRAW;
        end

        S_IDLE: begin
          r_plot <= 1'b0;
          if (enable && (do_erase || r_pending)) begin
            r_pending <= 1'b0;
            r_busy    <= 1'b1;
            r_p       <= '0;
            r_state   <= S_ERASE;
          end
        end

        S_ERASE: begin
          r_plot   <= 1'b1;
          r_x      <= w_pix_x;
          r_y      <= w_pix_y;
          r_colour <= BG_COLOUR;
          r_p      <= r_p + c_PIX_ONE;
          if (r_p == c_PIX_LAST) begin
            r_state <= S_MOVE;
          end
        end

        S_MOVE: begin
          r_plot   <= 1'b0;
          r_ball_x <= w_next_x;
          r_ball_y <= w_next_y;
          r_dir_x  <= w_next_dir_x;
          r_dir_y  <= w_next_dir_y;
          r_p      <= '0;
          r_state  <= S_DRAW;
        end

        S_DRAW: begin
          r_plot   <= 1'b1;
          r_x      <= w_pix_x;
          r_y      <= w_pix_y;
          r_colour <= BALL_COLOUR;
          r_p      <= r_p + c_PIX_ONE;
          if (r_p == c_PIX_LAST) begin
            // busy drops together with the last plot becoming visible
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_plot  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_colour;
  assign plot   = r_plot;
  assign busy   = r_busy;
  assign ball_x = r_ball_x;
  assign ball_y = r_ball_y;

endmodule
`default_nettype wire

// File: tb/tb_pong_ball_painter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_ball_painter
// Description : Self-checking bench for pong_ball_painter. A job-timeline
//               model predicts every output each cycle; literal pins anchor
//               the model at reset, first moves and wall bounces.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_ball_painter;

  localparam int BALL   = 4;
  localparam int XMAX   = 156;
  localparam int YMAX   = 116;
  localparam int X_INIT = 78;
  localparam int Y_INIT = 58;

  logic clock    = 1'b0;
  logic resetn   = 1'b0;
  logic enable   = 1'b1;
  logic do_erase = 1'b0;
`ifdef PONG_BALL_SPEED_EN
  logic [1:0] speed = 2'd0;
`endif

  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic [7:0] ball_x;
  logic [6:0] ball_y;

  int checks   = 0;
  int failures = 0;
  logic [17:0] plog[$];

  pong_ball_painter dut (
    .clock    (clock),
    .resetn   (resetn),
    .enable   (enable),
    .do_erase (do_erase),
`ifdef PONG_BALL_SPEED_EN
    .speed    (speed),
`endif
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .ball_x   (ball_x),
    .ball_y   (ball_y)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: a job is a timeline counted in clock edges from its start.
  // job 1 = power-up draw, job 2 = erase/move/draw.
  typedef struct {
    int bx, by, dx, dy, pend, job, t, ox, oy;
    int plot, busy, col, x, y, valid;
  } model_t;

  model_t m = '{default: 0};

  function automatic void axis(input int pos, input int dir, input int lim, input int step,
                               output int npos, output int ndir);
    int t;
    t    = pos + dir * step;
    npos = t;
    ndir = dir;
    if (t > lim) begin
      npos = lim - step;
      ndir = -1;
    end else if (t < 0) begin
      npos = step;
      ndir = 1;
    end
  endfunction

  function automatic model_t paint(input model_t s, input int ox, input int oy,
                                   input int idx, input int col);
    model_t n;
    n      = s;
    n.plot = 1;
    n.x    = ox + idx % BALL;
    n.y    = oy + idx / BALL;
    n.col  = col;
    return n;
  endfunction

  function automatic int cur_step();
`ifdef PONG_BALL_SPEED_EN
    return int'(speed) + 1;
`else
    return 1;
`endif
  endfunction

  function automatic model_t model_step(input model_t s, input logic rn, input logic en,
                                        input logic de, input int step);
    model_t n;
    int np, nd;
    n = s;
    if (!rn) begin
      n = '{default: 0};
      n.bx = X_INIT; n.by = Y_INIT; n.dx = 1; n.dy = 1;
      n.job = 1; n.t = -1; n.valid = 1;
      return n;
    end
    if (n.job == 0) begin
      if (en && (de || n.pend != 0)) begin
        n.job = 2; n.t = 0; n.pend = 0; n.ox = n.bx; n.oy = n.by;
      end
    end else begin
      if (en && de) n.pend = 1;
      n.t++;
    end
    n.plot = 0;
    n.busy = 0;
    if (n.job == 1) begin
      n.busy = (n.t < 16) ? 1 : 0;
      if (n.t >= 1 && n.t <= 16) n = paint(n, n.bx, n.by, n.t - 1, 7);
      if (n.t == 16) n.job = 0;
    end else if (n.job == 2) begin
      n.busy = (n.t < 33) ? 1 : 0;
      if (n.t >= 1 && n.t <= 16) n = paint(n, n.ox, n.oy, n.t - 1, 0);
      if (n.t == 17) begin
        axis(n.bx, n.dx, XMAX, step, np, nd); n.bx = np; n.dx = nd;
        axis(n.by, n.dy, YMAX, step, np, nd); n.by = np; n.dy = nd;
      end
      if (n.t >= 18 && n.t <= 33) n = paint(n, n.bx, n.by, n.t - 18, 7);
      if (n.t == 33) n.job = 0;
    end
    return n;
  endfunction

  // Advance the model on the same edge the DUT samples its inputs
  always @(posedge clock) m <= model_step(m, resetn, enable, do_erase, cur_step());

  // Compare every output against the model each cycle, and log plotted pixels
  always @(negedge clock) begin
    if (m.valid != 0) begin
      chk("cycle_outputs",
          64'({plot, busy, colour, x, y, ball_x, ball_y}),
          64'({1'(m.plot), 1'(m.busy), 3'(m.col), 8'(m.x), 7'(m.y), 8'(m.bx), 7'(m.by)}));
    end
    if (plot === 1'b1) plog.push_back({x, y, colour});
  end

  task automatic tick_and_wait();
    do_erase = 1'b1;
    @(negedge clock);
    do_erase = 1'b0;
    repeat (33) @(negedge clock);
  endtask

  initial begin
    int bcnt;
    int pcnt;

    // Reset state
    repeat (3) @(negedge clock);
    chk("reset_plot", 64'(plot), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ball", 64'({ball_x, ball_y}), 64'({8'd78, 7'd58}));
    chk("reset_xy_colour", 64'({x, y, colour}), 64'd0);

    // Power-up draw
    plog.delete();
    resetn = 1'b1;
    repeat (20) @(negedge clock);
    chk("init_plot_count", 64'(plog.size()), 64'd16);
    chk("init_first_pixel", 64'(plog.size() > 0 ? plog[0] : 18'h3ffff), 64'({8'd78, 7'd58, 3'd7}));
    chk("init_last_pixel", 64'(plog.size() > 15 ? plog[15] : 18'h3ffff), 64'({8'd81, 7'd61, 3'd7}));
    chk("init_busy_done", 64'(busy), 64'd0);

    // One tick: erase old sprite, move, redraw
    plog.delete();
    tick_and_wait();
    repeat (2) @(negedge clock);
    chk("move_plot_count", 64'(plog.size()), 64'd32);
    chk("erase_first_pixel", 64'(plog.size() > 0 ? plog[0] : 18'h3ffff), 64'({8'd78, 7'd58, 3'd0}));
    chk("erase_last_pixel", 64'(plog.size() > 15 ? plog[15] : 18'h3ffff), 64'({8'd81, 7'd61, 3'd0}));
    chk("draw_first_pixel", 64'(plog.size() > 16 ? plog[16] : 18'h3ffff), 64'({8'd79, 7'd59, 3'd7}));
    chk("ball_after_one", 64'({ball_x, ball_y}), 64'({8'd79, 7'd59}));

    // Disabled: ticks ignored
    enable = 1'b0;
    bcnt = 0;
    pcnt = 0;
    for (int i = 0; i < 40; i++) begin
      do_erase = (i % 3 == 0);
      @(negedge clock);
      bcnt += int'(busy);
      pcnt += int'(plot);
    end
    do_erase = 1'b0;
    chk("disabled_plots", 64'(pcnt), 64'd0);
    chk("disabled_busy", 64'(bcnt), 64'd0);
    enable = 1'b1;
    repeat (3) @(negedge clock);
    chk("disabled_no_pending", 64'(busy), 64'd0);

    // Ticks during a sequence: exactly one extra sequence follows
    plog.delete();
    bcnt = 0;
    do_erase = 1'b1;
    @(negedge clock);
    bcnt += int'(busy);
    do_erase = 1'b0;
    repeat (4) begin @(negedge clock); bcnt += int'(busy); end
    do_erase = 1'b1;
    repeat (3) begin @(negedge clock); bcnt += int'(busy); end
    do_erase = 1'b0;
    repeat (80) begin @(negedge clock); bcnt += int'(busy); end
    chk("pending_busy_cycles", 64'(bcnt), 64'd66);
    chk("pending_plot_count", 64'(plog.size()), 64'd64);
    chk("ball_after_three", 64'({ball_x, ball_y}), 64'({8'd81, 7'd61}));

    // Wall bounces (ticks counted from reset, three already done)
    for (int k = 4; k <= 175; k++) begin
      tick_and_wait();
      if (k == 58)  chk("y_reaches_bottom", 64'(ball_y), 64'd116);
      if (k == 59)  chk("y_bounce_bottom", 64'(ball_y), 64'd115);
      if (k == 78)  chk("x_reaches_right", 64'(ball_x), 64'd156);
      if (k == 79)  chk("x_bounce_right", 64'(ball_x), 64'd155);
      if (k == 174) chk("y_reaches_top", 64'(ball_y), 64'd0);
      if (k == 175) chk("y_bounce_top", 64'({ball_x, ball_y}), 64'({8'd59, 7'd1}));
    end

    // Reset in the middle of DRAW
    do_erase = 1'b1;
    @(negedge clock);
    do_erase = 1'b0;
    repeat (20) @(negedge clock);
    chk("pre_reset_drawing", 64'(plot), 64'd1);
    resetn = 1'b0;
    @(negedge clock);
    chk("midreset_plot", 64'(plot), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_ball", 64'({ball_x, ball_y}), 64'({8'd78, 7'd58}));
    plog.delete();
    resetn = 1'b1;
    repeat (20) @(negedge clock);
    chk("redraw_plot_count", 64'(plog.size()), 64'd16);
    chk("redraw_first_pixel", 64'(plog.size() > 0 ? plog[0] : 18'h3ffff), 64'({8'd78, 7'd58, 3'd7}));

`ifdef PONG_BALL_SPEED_EN
    // Fast ball: 4 px per tick, bounce off the right wall
    speed = 2'd3;
    for (int k = 1; k <= 21; k++) begin
      tick_and_wait();
      if (k == 19) chk("speed_x_154", 64'(ball_x), 64'd154);
      if (k == 20) chk("speed_bounce_152", 64'(ball_x), 64'd152);
      if (k == 21) chk("speed_reversed_148", 64'(ball_x), 64'd148);
    end
    speed = 2'd0;
`endif

    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
